// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory bus interface.
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RESP   = 2'b10;

    // Word needs addr[1:0]==0, half needs addr[0]==0; bytes (and size 11) never fault.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_WORD) && (addr_lo != 2'b00)) ||
               ((size == SZ_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/dmem_bus_if_if.sv
// Request/response handshake between the memory-access stage and dmem_bus_if.
interface dmem_bus_if_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/dmem_load_ext.sv
// Load lane extract with sign/zero extension; size 11 behaves as byte.
module dmem_load_ext
    import dmem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic              sgn,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = raw;
        case (size)
            SZ_WORD: result = raw;
            SZ_HALF: result = {{(DATA_W-16){sgn & raw[15]}}, raw[15:0]};
            default: result = {{(DATA_W-8){sgn & raw[7]}}, raw[7:0]};
        endcase
    end

endmodule

// File: rtl/dmem_bus_if.sv
// Single-outstanding load/store engine driving the external DAD/DDT/MREQ bus.
// Optional bus watchdog enabled with `define DMEM_TIMEOUT_EN.
module dmem_bus_if
    import dmem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    dmem_bus_if_if.slave      cpu,
    output logic [ADDR_W-1:0] DAD,
    output logic              MREQ,
    output logic              WRITE,
    output logic [1:0]        SIZE,
    inout  wire  [DATA_W-1:0] DDT,
    input  logic              ACKD_n
);

    logic [1:0]        state;
    logic              sgn_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] st_data;
    logic [DATA_W-1:0] ld_data;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              to_hit;

    assign cpu.req_ready  = (state == ST_IDLE);
    assign cpu.resp_valid = (state == ST_RESP);
    assign cpu.resp_err   = resp_err_q;
    assign cpu.resp_rdata = resp_rdata_q;

    always_comb begin
        st_data = wdata_q;
        case (SIZE)
            SZ_WORD: st_data = wdata_q;
            SZ_HALF: st_data = {{(DATA_W-16){1'b0}}, wdata_q[15:0]};
            default: st_data = {{(DATA_W-8){1'b0}}, wdata_q[7:0]};
        endcase
    end

    // WRITE clears on the ack edge, so the bus is released as soon as ACCESS ends.
    assign DDT = ((state == ST_ACCESS) && WRITE) ? st_data : {DATA_W{1'bz}};

    dmem_load_ext #(.DATA_W(DATA_W)) u_ext (
        .size   (SIZE),
        .sgn    (sgn_q),
        .raw    (DDT),
        .result (ld_data)
    );

`ifdef DMEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // to_cnt holds the number of ACCESS edges already spent waiting.
    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    to_cnt <= '0;
        else if (state != ST_ACCESS) to_cnt <= '0;
        else                         to_cnt <= to_cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign to_hit     = 1'b0;
    assign unused_cfg = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            DAD          <= '0;
            SIZE         <= SZ_WORD;
            MREQ         <= 1'b0;
            WRITE        <= 1'b0;
            sgn_q        <= 1'b0;
            wdata_q      <= '0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu.req_valid) begin
                        if (misaligned(cpu.req_size, cpu.req_addr[1:0])) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= ST_RESP;
                        end else begin
                            DAD     <= cpu.req_addr;
                            SIZE    <= cpu.req_size;
                            WRITE   <= cpu.req_write;
                            MREQ    <= 1'b1;
                            sgn_q   <= cpu.req_signed;
                            wdata_q <= cpu.req_wdata;
                            state   <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!ACKD_n) begin
                        MREQ         <= 1'b0;
                        WRITE        <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= WRITE ? '0 : ld_data;
                        state        <= ST_RESP;
                    end else if (to_hit) begin
                        MREQ         <= 1'b0;
                        WRITE        <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
